// File: rtl/ebr_pkg.sv
// ebr_pkg: shared types and helpers for the burst-access embedded RAM.
//   burst_state_t : per-port burst FSM state (IDLE, BURST)
//   wrap_inc      : pointer increment that wraps at the memory depth
package ebr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    // Next address after ptr in a memory of 'size' words; wraps size-1 -> 0.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] size);
        return (ptr >= size - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ebr_burst_ctrl.sv
// ebr_burst_ctrl: burst sequencer for one memory port.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request a new burst (validated against addr/len/state)
//   addr, len  : burst start address and beat count
//   beat       : one beat presented this cycle (write valid / read enable)
//   busy       : port is in BURST
//   fire_c     : beat is accepted this cycle (combinational)
//   last_c     : accepted beat is the final one of the burst (combinational)
//   ptr        : memory address of the current beat
module ebr_burst_ctrl
    import ebr_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  beat,
    output logic                  busy,
    output logic                  fire_c,
    output logic                  last_c,
    output logic [ADDR_WIDTH-1:0] ptr
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] SIZE_W = CW'(SIZE);

    burst_state_t          state;
    burst_state_t          state_nxt;
    logic [ADDR_WIDTH-1:0] ptr_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  start_ok_c;

    // Start is only honoured for a non-empty burst that fits and begins inside the array.
    assign start_ok_c = start && (len != '0) && (len <= SIZE_W) && ({1'b0, addr} < SIZE_W);
    assign fire_c     = (state == BURST) && beat;
    assign last_c     = fire_c && (cnt == CW'(1));
    assign busy       = (state == BURST);

    // State, pointer and remaining-beat registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start_ok_c) begin
                    state_nxt = BURST;
                    ptr_nxt   = addr;
                    cnt_nxt   = len;
                end
            end
            BURST: begin
                if (beat) begin
                    ptr_nxt = ADDR_WIDTH'(wrap_inc(32'(ptr), 32'(SIZE)));
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/ebr_burst.sv
// ebr_burst: single-clock embedded RAM with independent write and read burst ports.
//   clk, rst_n                      : clock, synchronous active-low reset
//   wr_start, wr_addr, wr_len       : open a write burst
//   wr_valid, wr_data, wr_be        : write beat with per-byte enables
//   wr_busy, wr_done                : write burst active / pulse after the final beat
//   rd_start, rd_addr, rd_len       : open a read burst
//   rd_en                           : issue one read beat
//   rd_busy, rd_valid, rd_data, rd_last : read burst active / returned data stream
module ebr_burst
    import ebr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = $clog2(SIZE),
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_start,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [ADDR_WIDTH:0]     wr_len,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    wr_busy,
    output logic                    wr_done,
    input  logic                    rd_start,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [ADDR_WIDTH:0]     rd_len,
    input  logic                    rd_en,
    output logic                    rd_busy,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [SIZE];

    logic                  wr_fire_c;
    logic                  wr_last_c;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  rd_fire_c;
    logic                  rd_last_c;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] be_mask_c;

    logic                  rd_valid_q;
    logic                  rd_last_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    ebr_burst_ctrl #(
        .SIZE       (SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (wr_start),
        .addr   (wr_addr),
        .len    (wr_len),
        .beat   (wr_valid),
        .busy   (wr_busy),
        .fire_c (wr_fire_c),
        .last_c (wr_last_c),
        .ptr    (wr_ptr)
    );

    ebr_burst_ctrl #(
        .SIZE       (SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (rd_start),
        .addr   (rd_addr),
        .len    (rd_len),
        .beat   (rd_en),
        .busy   (rd_busy),
        .fire_c (rd_fire_c),
        .last_c (rd_last_c),
        .ptr    (rd_ptr)
    );

    // Expand byte enables into a bit mask.
    for (genvar g = 0; g < NB; g++) begin : g_be_mask
        assign be_mask_c[g*8 +: 8] = {8{wr_be[g]}};
    end

    // Array write; no reset so contents survive rst_n, and a reset cycle writes nothing.
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire_c) begin
            mem[wr_ptr] <= (mem[wr_ptr] & ~be_mask_c) | (wr_data & be_mask_c);
        end
    end

    // Write completion pulse, one cycle after the final beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_done <= 1'b0;
        end else begin
            wr_done <= wr_last_c;
        end
    end

    // First read stage; the array write is non-blocking, so a same-address read sees old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_fire_c;
            rd_last_q  <= rd_last_c;
            if (rd_fire_c) begin
                rd_data_q <= mem[rd_ptr];
            end
        end
    end

    // Optional output register; data only moves with a valid beat so rd_data holds otherwise.
    if (OUT_REG != 0) begin : g_out_reg
        logic                  valid_q2;
        logic                  last_q2;
        logic [DATA_WIDTH-1:0] data_q2;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q2 <= 1'b0;
                last_q2  <= 1'b0;
                data_q2  <= '0;
            end else begin
                valid_q2 <= rd_valid_q;
                last_q2  <= rd_last_q;
                if (rd_valid_q) begin
                    data_q2 <= rd_data_q;
                end
            end
        end

        assign rd_valid = valid_q2;
        assign rd_last  = last_q2;
        assign rd_data  = data_q2;
    end else begin : g_no_out_reg
        assign rd_valid = rd_valid_q;
        assign rd_last  = rd_last_q;
        assign rd_data  = rd_data_q;
    end

endmodule
